// File: rtl/retrosoc_gpio_pkg.sv
// Shared register map, reset values and bus helpers for the retroSoC GPIO bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package retrosoc_gpio_pkg;

  // Byte offsets of the eight 32-bit registers (decoded from addr[4:2]).
  localparam logic [4:0] GPIO_OUT_OFS     = 5'h00;
  localparam logic [4:0] GPIO_OE_OFS      = 5'h04;
  localparam logic [4:0] GPIO_IN_OFS      = 5'h08;
  localparam logic [4:0] GPIO_IE_OFS      = 5'h0C;
  localparam logic [4:0] GPIO_RISE_EN_OFS = 5'h10;
  localparam logic [4:0] GPIO_FALL_EN_OFS = 5'h14;
  localparam logic [4:0] GPIO_IP_OFS      = 5'h18;
  localparam logic [4:0] GPIO_DBCNT_OFS   = 5'h1C;

  // Every register, synchroniser stage and bus output clears to zero.
  localparam logic [31:0] GPIO_REG_RST = 32'h0000_0000;

  // Bus slave sequencing: accept in IDLE, pulse ready in RESP, then idle again.
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_st_e;

  // Expand byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/retrosoc_gpio_if.sv
// SoC native memory bus (valid/ready) connecting the core to the GPIO bank.
// Latency: n/a (wires only).
// Backpressure: master holds mem_valid_i until the slave pulses mem_ready_o.
// Signals: mem_valid_i/mem_addr_i/mem_wdata_i/mem_wstrb_i (master -> slave),
//          mem_rdata_o/mem_ready_o (slave -> master).
interface retrosoc_gpio_if;
  logic        mem_valid_i;
  logic [4:0]  mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;

  modport master (
    output mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    input  mem_rdata_o, mem_ready_o
  );

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    output mem_rdata_o, mem_ready_o
  );
endinterface

// File: rtl/retrosoc_gpio_sync.sv
// Per-bit two-flop synchroniser for asynchronous pad inputs.
// Latency: 2 cycles from d_i to q_o.
// Backpressure: none (free-running).
// Ports: clk_i, rst_i (async active-high), d_i[WIDTH] raw input, q_o[WIDTH] synchronised.
module retrosoc_gpio_sync
  import retrosoc_gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= GPIO_REG_RST[WIDTH-1:0];
      sync2_q <= GPIO_REG_RST[WIDTH-1:0];
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/retrosoc_gpio_bank.sv
// NUM_GPIO-channel GPIO bank: pad out/oe, synchronised inputs, edge IRQs with W1C pending.
// Latency: bus ready 1 cycle after valid; pad in -> IN 3 cycles, IP 4, irq_o 5 (no debounce).
// Backpressure: one access per two cycles; mem_valid_i is held until the ready pulse.
// Ports: clk_i, rst_i (async active-high), bus (slave modport of retrosoc_gpio_if),
//        gpio_out_o/gpio_oe_o pad drive, gpio_in_i raw pads, irq_o = registered |(IP & IE).
// Optional: define GPIO_DEBOUNCE_EN to build the prescaled two-sample input filter.
module retrosoc_gpio_bank
  import retrosoc_gpio_pkg::*;
#(
  parameter int NUM_GPIO = 8,
  parameter int DB_CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  retrosoc_gpio_if.slave      bus,
  output logic [NUM_GPIO-1:0] gpio_out_o,
  output logic [NUM_GPIO-1:0] gpio_oe_o,
  input  logic [NUM_GPIO-1:0] gpio_in_i,
  output logic                irq_o
);

  bus_st_e             bus_state_q, bus_state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_GPIO-1:0] out_q, out_d, oe_q, oe_d, ie_q, ie_d;
  logic [NUM_GPIO-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NUM_GPIO-1:0] ip_q, ip_d, in_q, in_d, in_prev_q, in_prev_d;
  logic                irq_q, irq_d;

  logic                accept, wr_en;
  logic [4:0]          reg_ofs;
  logic [31:0]         wmask32, rd_val;
  logic [NUM_GPIO-1:0] wmask, wdat, ip_clr, rise_evt, fall_evt, sync2;

  retrosoc_gpio_sync #(.WIDTH(NUM_GPIO)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (gpio_in_i),
    .q_o   (sync2)
  );

  always_comb begin
    accept  = (bus_state_q == BUS_IDLE) && bus.mem_valid_i;
    wr_en   = accept && (bus.mem_wstrb_i != 4'b0000);
    reg_ofs = {bus.mem_addr_i[4:2], 2'b00};
    wmask32 = strb_mask(bus.mem_wstrb_i);
    wmask   = wmask32[NUM_GPIO-1:0];
    wdat    = bus.mem_wdata_i[NUM_GPIO-1:0];
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] dbcnt_q, dbcnt_d, pre_q, pre_d;
  logic [NUM_GPIO-1:0] hist0_q, hist0_d, hist1_q, hist1_d, hist_eq;
  logic [31:0]         dbcnt_wr_val;
  logic                dbcnt_wr, tick;

  always_comb begin
    dbcnt_wr     = wr_en && (reg_ofs == GPIO_DBCNT_OFS);
    dbcnt_wr_val = (32'(dbcnt_q) & ~wmask32) | (bus.mem_wdata_i & wmask32);
    dbcnt_d      = dbcnt_wr ? dbcnt_wr_val[DB_CNT_W-1:0] : dbcnt_q;
    // Shared prescaler: tick on reaching DBCNT, restart on wrap or reprogramming.
    tick         = (pre_q == dbcnt_q);
    pre_d        = (dbcnt_wr || tick) ? '0 : pre_q + DB_CNT_W'(1);
    hist0_d      = tick ? sync2 : hist0_q;
    hist1_d      = tick ? hist0_q : hist1_q;
    // A pin only changes once two consecutive tick samples agree.
    hist_eq      = ~(hist0_q ^ hist1_q);
    if (dbcnt_q == '0) in_d = sync2;
    else               in_d = (hist_eq & hist0_q) | (~hist_eq & in_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbcnt_q <= GPIO_REG_RST[DB_CNT_W-1:0];
      pre_q   <= '0;
      hist0_q <= '0;
      hist1_q <= '0;
    end else begin
      dbcnt_q <= dbcnt_d;
      pre_q   <= pre_d;
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
    end
  end
`else
  always_comb in_d = sync2;
`endif

  always_comb begin
    bus_state_d = bus_state_q;
    rdata_d     = '0;
    rd_val      = '0;
    out_d       = out_q;
    oe_d        = oe_q;
    ie_d        = ie_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    ip_clr      = '0;
    in_prev_d   = in_q;

    case (bus_state_q)
      BUS_IDLE: if (accept) bus_state_d = BUS_RESP;
      BUS_RESP: bus_state_d = BUS_IDLE;  // forced idle cycle; valid still high here is ignored
      default:  bus_state_d = BUS_IDLE;
    endcase

    case (reg_ofs)
      GPIO_OUT_OFS:     rd_val = 32'(out_q);
      GPIO_OE_OFS:      rd_val = 32'(oe_q);
      GPIO_IN_OFS:      rd_val = 32'(in_q);
      GPIO_IE_OFS:      rd_val = 32'(ie_q);
      GPIO_RISE_EN_OFS: rd_val = 32'(rise_en_q);
      GPIO_FALL_EN_OFS: rd_val = 32'(fall_en_q);
      GPIO_IP_OFS:      rd_val = 32'(ip_q);
      GPIO_DBCNT_OFS: begin
`ifdef GPIO_DEBOUNCE_EN
        rd_val = 32'(dbcnt_q);
`else
        rd_val = '0;
`endif
      end
      default:          rd_val = '0;
    endcase
    if (accept) rdata_d = rd_val;

    if (wr_en) begin
      case (reg_ofs)
        GPIO_OUT_OFS:     out_d     = (out_q & ~wmask) | (wdat & wmask);
        GPIO_OE_OFS:      oe_d      = (oe_q & ~wmask) | (wdat & wmask);
        GPIO_IE_OFS:      ie_d      = (ie_q & ~wmask) | (wdat & wmask);
        GPIO_RISE_EN_OFS: rise_en_d = (rise_en_q & ~wmask) | (wdat & wmask);
        GPIO_FALL_EN_OFS: fall_en_d = (fall_en_q & ~wmask) | (wdat & wmask);
        GPIO_IP_OFS:      ip_clr    = wdat & wmask;
        default:          ;
      endcase
    end

    rise_evt = in_q & ~in_prev_q & rise_en_q;
    fall_evt = ~in_q & in_prev_q & fall_en_q;
    // New events are ORed in after the W1C clear so a coincident event is kept.
    ip_d     = (ip_q & ~ip_clr) | rise_evt | fall_evt;
    irq_d    = |(ip_q & ie_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_state_q <= BUS_IDLE;
      rdata_q     <= GPIO_REG_RST;
      out_q       <= GPIO_REG_RST[NUM_GPIO-1:0];
      oe_q        <= GPIO_REG_RST[NUM_GPIO-1:0];
      ie_q        <= GPIO_REG_RST[NUM_GPIO-1:0];
      rise_en_q   <= GPIO_REG_RST[NUM_GPIO-1:0];
      fall_en_q   <= GPIO_REG_RST[NUM_GPIO-1:0];
      ip_q        <= GPIO_REG_RST[NUM_GPIO-1:0];
      in_q        <= GPIO_REG_RST[NUM_GPIO-1:0];
      in_prev_q   <= GPIO_REG_RST[NUM_GPIO-1:0];
      irq_q       <= 1'b0;
    end else begin
      bus_state_q <= bus_state_d;
      rdata_q     <= rdata_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      ie_q        <= ie_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      ip_q        <= ip_d;
      in_q        <= in_d;
      in_prev_q   <= in_prev_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.mem_ready_o = (bus_state_q == BUS_RESP);
  assign bus.mem_rdata_o = rdata_q;
  assign gpio_out_o      = out_q;
  assign gpio_oe_o       = oe_q;
  assign irq_o           = irq_q;

  // Address byte lane and data bits above NUM_GPIO are architecturally don't-care.
  logic unused_ok;
  assign unused_ok = ^{bus.mem_addr_i[1:0], bus.mem_wdata_i, wmask32, 32'(DB_CNT_W)};

endmodule

// File: tb/tb_retrosoc_gpio_bank.sv
`timescale 1ns/1ps
module tb_retrosoc_gpio_bank;

  localparam int          NG    = 8;
  localparam logic [31:0] VMASK = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          rst;
  logic [NG-1:0] gpio_out, gpio_oe, gpio_in;
  logic          irq;

  retrosoc_gpio_if bus();

  retrosoc_gpio_bank #(.NUM_GPIO(NG), .DB_CNT_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .gpio_out_o (gpio_out),
    .gpio_oe_o  (gpio_oe),
    .gpio_in_i  (gpio_in),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: one entry per issued bus access, popped on each ready pulse.
  logic        sb_rd  [$];
  logic [31:0] sb_exp [$];
  logic [4:0]  sb_ofs [$];

  // Reference model of the software-visible state.
  logic [31:0] m_out, m_oe, m_ie, m_rise, m_fall, m_ip, m_pins, m_dbcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s, input logic [31:0] keep);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return ((old & ~m) | (d & m)) & keep;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    case (idx)
      0: m_out  = merge(m_out, d, s, VMASK);
      1: m_oe   = merge(m_oe, d, s, VMASK);
      3: m_ie   = merge(m_ie, d, s, VMASK);
      4: m_rise = merge(m_rise, d, s, VMASK);
      5: m_fall = merge(m_fall, d, s, VMASK);
      6: m_ip   = m_ip & ~merge(32'h0, d, s, VMASK);
`ifdef GPIO_DEBOUNCE_EN
      7: m_dbcnt = merge(m_dbcnt, d, s, 32'h0000_FFFF);
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return m_out;
      1: return m_oe;
      2: return m_pins;
      3: return m_ie;
      4: return m_rise;
      5: return m_fall;
      6: return m_ip;
      default: return m_dbcnt;
    endcase
  endfunction

  task automatic bus_xfer(input logic [4:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rd);
    int n;
    @(negedge clk);
    bus.mem_valid_i = 1'b1;
    bus.mem_addr_i  = addr;
    bus.mem_wdata_i = wdata;
    bus.mem_wstrb_i = wstrb;
    sb_rd.push_back(wstrb == 4'b0000);
    sb_exp.push_back(exp_rd);
    sb_ofs.push_back(addr);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.mem_ready_o && n < 8);
    check("ready_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    bus.mem_valid_i = 1'b0;
    bus.mem_wstrb_i = 4'b0000;
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] s);
    bus_xfer(5'(idx * 4), d, s, 32'h0);
    model_write(idx, d, s);
  endtask

  task automatic rd(input int idx, input logic [1:0] lo);
    bus_xfer({3'(idx), lo}, 32'h0, 4'b0000, model_read(idx));
  endtask

  // Change pads, fold the resulting enabled edges into the model, let them settle.
  task automatic set_pins(input logic [31:0] v);
    @(negedge clk);
    m_ip    = m_ip | (((v & ~m_pins & m_rise) | (~v & m_pins & m_fall)) & VMASK);
    m_pins  = v & VMASK;
    gpio_in = v[NG-1:0];
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every ready pulse.
  initial begin
    logic        prev_rdy;
    logic        r;
    logic [31:0] e;
    logic [4:0]  o;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready_o) begin
        check("ready_one_cycle", 32'(prev_rdy), 32'd0);
        if (sb_rd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got ready with no request pending, required none");
        end else begin
          r = sb_rd.pop_front();
          e = sb_exp.pop_front();
          o = sb_ofs.pop_front();
          if (r) check($sformatf("rdata_ofs%02h", o), bus.mem_rdata_o, e);
        end
      end
      prev_rdy = bus.mem_ready_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  int wr_tab [6] = '{0, 1, 3, 4, 5, 6};

  initial begin
    int op, idx;
    bus.mem_valid_i = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    bus.mem_wstrb_i = '0;
    gpio_in = '0;
    rst     = 1'b1;
    {m_out, m_oe, m_ie, m_rise, m_fall, m_ip, m_pins, m_dbcnt} = '0;

    // Reset with a request pending: no ready, all outputs quiet.
    bus.mem_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", 32'(bus.mem_ready_o), 32'd0);
      check("rst_rdata", bus.mem_rdata_o, 32'h0);
      check("rst_out", 32'(gpio_out), 32'h0);
      check("rst_oe", 32'(gpio_oe), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
    end
    bus.mem_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) bus_xfer(5'(i * 4), 32'h0, 4'b0000, 32'h0);

    // Byte strobes and pad drive.
    wr(0, 32'hFFFF_FFA5, 4'b0001);
    wr(1, 32'h0000_00FF, 4'b1111);
    check("gpio_out_a5", 32'(gpio_out), 32'h0000_00A5);
    check("gpio_oe_ff", 32'(gpio_oe), 32'h0000_00FF);
    bus_xfer(5'h00, 32'h0, 4'b0000, 32'h0000_00A5);

    // Rising edge on pin 0: IN visible after 3 edges, irq on the 5th.
    wr(4, 32'h1, 4'b1111);
    wr(3, 32'h1, 4'b1111);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    m_pins     = 32'h1;
    @(posedge clk);
    @(posedge clk);
    fork
      begin
        bus_xfer(5'h08, 32'h0, 4'b0000, 32'h0);
        bus_xfer(5'h08, 32'h0, 4'b0000, 32'h1);
      end
      begin
        @(posedge clk); #1; check("irq_edge3", 32'(irq), 32'd0);
        @(posedge clk); #1; check("irq_edge4", 32'(irq), 32'd0);
        @(posedge clk); #1; check("irq_edge5", 32'(irq), 32'd1);
      end
    join
    m_ip = 32'h1;
    wr(6, 32'h1, 4'b1111);
    check("irq_after_w1c", 32'(irq), 32'd0);

    // Falling edge with IE off latches IP but keeps irq low.
    wr(5, 32'h2, 4'b1111);
    wr(3, 32'h0, 4'b1111);
    set_pins(m_pins | 32'h2);
    set_pins(m_pins & ~32'h2);
    check("irq_ie_off", 32'(irq), 32'd0);
    bus_xfer(5'h18, 32'h0, 4'b0000, 32'h2);
    wr(3, 32'h2, 4'b1111);
    check("irq_ie_on", 32'(irq), 32'd1);
    wr(6, 32'hFF, 4'b1111);
    check("irq_cleared", 32'(irq), 32'd0);

    // W1C coinciding with a new rise on pin 0: the set is kept.
    set_pins(m_pins & ~32'h1);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    m_pins     = m_pins | 32'h1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    bus_xfer(5'h18, 32'h1, 4'b1111, 32'h0);
    m_ip = 32'h1;
    bus_xfer(5'h18, 32'h0, 4'b0000, 32'h1);
    wr(6, 32'hFF, 4'b1111);

`ifdef GPIO_DEBOUNCE_EN
    wr(7, 32'h3, 4'b1111);
    rd(7, 2'b00);
    wr(4, 32'h5, 4'b1111);
    @(negedge clk);
    gpio_in[2] = 1'b1;
    repeat (2) @(negedge clk);
    gpio_in[2] = 1'b0;
    repeat (20) @(posedge clk);
    rd(2, 2'b00);
    bus_xfer(5'h18, 32'h0, 4'b0000, 32'h0);
    @(negedge clk);
    gpio_in[2] = 1'b1;
    m_pins     = m_pins | 32'h4;
    m_ip       = m_ip | 32'h4;
    repeat (12) @(posedge clk);
    bus_xfer(5'h08, 32'h0, 4'b0000, m_pins);
    rd(6, 2'b00);
    wr(6, 32'hFF, 4'b1111);
    wr(7, 32'h0, 4'b1111);
`else
    bus_xfer(5'h1C, 32'h3, 4'b1111, 32'h0);
    bus_xfer(5'h1C, 32'h0, 4'b0000, 32'h0);
`endif

    // Randomised register traffic, reads and pad activity against the model.
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 2);
      case (op)
        0: begin
          idx = wr_tab[$urandom_range(0, 5)];
          wr(idx, $urandom, 4'($urandom_range(1, 15)));
          check("rnd_gpio_out", 32'(gpio_out), m_out);
          check("rnd_gpio_oe", 32'(gpio_oe), m_oe);
          check("rnd_irq_wr", 32'(irq), 32'(|(m_ip & m_ie)));
        end
        1: rd($urandom_range(0, 7), 2'($urandom_range(0, 3)));
        default: begin
          set_pins(32'($urandom_range(0, 255)));
          check("rnd_irq_pins", 32'(irq), 32'(|(m_ip & m_ie)));
        end
      endcase
    end

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
